fetch_pc_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_pc_unit_if.sv | 27 ++
 rtl/fetch_pc_unit_npc_select.sv | 25 ++
 rtl/fetch_pc_unit.sv | 137 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and reset/exception vectors.
// Fetch FSM states, redirect priorities and the next-PC bundle.
package cpu_pkg;

  typedef enum logic [1:0] {
    F_REQ,
    F_WAIT,
    F_HOLD
  } fstate_e;

  typedef enum logic [1:0] {
    P_NONE,
    P_JMP,
    P_BR,
    P_EXC
  } prio_e;

  typedef struct packed {
    logic        redirect;
    prio_e       prio;
    logic [31:0] target;
  } npc_t;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] EXC_PC   = 32'hBFC00380;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// SRAM-like instruction bus, one outstanding request.
// master: fetch unit (req/addr out, addr_ok/data_ok/rdata in).
interface fetch_pc_unit_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );

endinterface

// File: rtl/fetch_pc_unit_npc_select.sv
// Redirect priority mux: exception > branch > jump.
// Ports: three redirect sources in, npc_o {redirect, prio, target} out.
module npc_select
  import cpu_pkg::*;
(
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        br_redirectE,
  input  logic [31:0] br_targetE,
  input  logic        jump1D,
  input  logic [31:0] pc_jump1D,
  output npc_t        npc_o
);

  always_comb begin
    npc_o = '{1'b0, P_NONE, 32'h0};
    priority case (1'b1)
      exc_valid:    npc_o = '{1'b1, P_EXC, exc_pc};
      br_redirectE: npc_o = '{1'b1, P_BR, br_targetE};
      jump1D:       npc_o = '{1'b1, P_JMP, pc_jump1D};
      default:      npc_o = '{1'b0, P_NONE, 32'h0};
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator and instruction-fetch sequencer (REQ/WAIT/HOLD).
// Ports: clk/resetn, redirect sources, stallF, ibus master, F/D outputs.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   exc_valid,
  input  logic [31:0]            exc_pc,
  input  logic                   br_redirectE,
  input  logic [31:0]            br_targetE,
  input  logic                   jump1D,
  input  logic [31:0]            pc_jump1D,
  input  logic                   stallF,
  fetch_pc_unit_if.master        ibus,
  output logic [31:0]            instrF,
  output logic [31:0]            pcF,
  output logic [31:0]            PcPlus4F,
  output logic                   validF
);

  import cpu_pkg::*;

  fstate_e     state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;
  prio_e       pend_prio_q, pend_prio_d;
  logic        discard_q, discard_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  npc_t        npc;
  logic        take_new;

  npc_select u_npc (
    .exc_valid    (exc_valid),
    .exc_pc       (exc_pc),
    .br_redirectE (br_redirectE),
    .br_targetE   (br_targetE),
    .jump1D       (jump1D),
    .pc_jump1D    (pc_jump1D),
    .npc_o        (npc)
  );

  // A later redirect only replaces a pending one
  // if it outranks it.
  assign take_new = npc.redirect
    & (~pend_valid_q | (npc.prio > pend_prio_q));

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    pend_prio_d  = pend_prio_q;
    discard_d    = discard_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    unique case (state_q)
      F_REQ: begin
        // Address must stay stable until accepted,
        // so redirects are parked in pend_*.
        if (take_new) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = npc.target;
          pend_prio_d  = npc.prio;
        end
        if (ibus.inst_addr_ok) begin
          state_d   = F_WAIT;
          discard_d = pend_valid_q | npc.redirect;
        end
      end
      F_WAIT: begin
        if (ibus.inst_data_ok) begin
          state_d      = F_REQ;
          pend_valid_d = 1'b0;
          pend_prio_d  = P_NONE;
          discard_d    = 1'b0;
          if (take_new) begin
            fetch_pc_d = npc.target;
          end else if (discard_q | pend_valid_q) begin
            fetch_pc_d = pend_pc_q;
          end else begin
            buf_instr_d = ibus.inst_rdata;
            buf_pc_d    = fetch_pc_q;
            state_d     = F_HOLD;
          end
        end else if (take_new) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = npc.target;
          pend_prio_d  = npc.prio;
          discard_d    = 1'b1;
        end
      end
      F_HOLD: begin
        if (npc.redirect) begin
          fetch_pc_d = npc.target;
          state_d    = F_REQ;
        end else if (!stallF) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = F_REQ;
        end
      end
      default: state_d = F_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= F_REQ;
      fetch_pc_q   <= RESET_PC;
      pend_pc_q    <= 32'h0;
      pend_valid_q <= 1'b0;
      pend_prio_q  <= P_NONE;
      discard_q    <= 1'b0;
      buf_instr_q  <= 32'h0;
      buf_pc_q     <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_prio_q  <= pend_prio_d;
      discard_q    <= discard_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
    end
  end

  assign ibus.inst_req  = resetn & (state_q == F_REQ);
  assign ibus.inst_addr = fetch_pc_q;
  assign validF         = resetn & (state_q == F_HOLD);
  assign instrF         = buf_instr_q;
  assign pcF            = buf_pc_q;
  assign PcPlus4F       = buf_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random
// redirects/bus timing against a request-lifecycle model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST = 32'hBFC00000;
  localparam logic [31:0] EXC = 32'hBFC00380;

  logic        clk;
  logic        resetn;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        br_redirectE;
  logic [31:0] br_targetE;
  logic        jump1D;
  logic [31:0] pc_jump1D;
  logic        stallF;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic [31:0] PcPlus4F;
  logic        validF;

  fetch_pc_unit_if ibus ();

  fetch_pc_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .exc_valid    (exc_valid),
    .exc_pc       (exc_pc),
    .br_redirectE (br_redirectE),
    .br_targetE   (br_targetE),
    .jump1D       (jump1D),
    .pc_jump1D    (pc_jump1D),
    .stallF       (stallF),
    .ibus         (ibus),
    .instrF       (instrF),
    .pcF          (pcF),
    .PcPlus4F     (PcPlus4F),
    .validF       (validF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;

  // Model: where the next/current request points, whether it
  // was accepted, whether a word is held for decode, and the
  // strongest redirect seen since the request was issued.
  logic        m_busy;
  logic        m_hold;
  logic [31:0] m_pc;
  logic [31:0] m_hold_pc;
  logic [31:0] m_hold_ins;
  logic        m_rv;
  int          m_rp;
  logic [31:0] m_rpc;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    exc_valid         = 1'b0;
    exc_pc            = 32'h0;
    br_redirectE      = 1'b0;
    br_targetE        = 32'h0;
    jump1D            = 1'b0;
    pc_jump1D         = 32'h0;
    stallF            = 1'b0;
    ibus.inst_addr_ok = 1'b0;
    ibus.inst_data_ok = 1'b0;
    ibus.inst_rdata   = 32'h0;
  endtask

  task automatic compare();
    logic exp_req;
    logic exp_val;
    exp_req = resetn && !m_busy && !m_hold;
    exp_val = resetn && m_hold;
    chk("inst_req", {31'b0, ibus.inst_req}, {31'b0, exp_req});
    if (exp_req) chk("inst_addr", ibus.inst_addr, m_pc);
    chk("validF", {31'b0, validF}, {31'b0, exp_val});
    if (exp_val) begin
      chk("instrF", instrF, m_hold_ins);
      chk("pcF", pcF, m_hold_pc);
      chk("PcPlus4F", PcPlus4F, m_hold_pc + 32'd4);
    end
  endtask

  task automatic model_step();
    int          rp;
    logic [31:0] rpc;
    rp  = 0;
    rpc = 32'h0;
    if (exc_valid) begin
      rp = 3; rpc = exc_pc;
    end else if (br_redirectE) begin
      rp = 2; rpc = br_targetE;
    end else if (jump1D) begin
      rp = 1; rpc = pc_jump1D;
    end
    if (!resetn) begin
      m_busy = 1'b0;
      m_hold = 1'b0;
      m_pc   = RST;
      m_rv   = 1'b0;
    end else if (m_hold) begin
      if (rp > 0) begin
        m_pc   = rpc;
        m_hold = 1'b0;
      end else if (!stallF) begin
        m_pc   = m_hold_pc + 32'd4;
        m_hold = 1'b0;
      end
    end else begin
      if (rp > (m_rv ? m_rp : 0)) begin
        m_rv  = 1'b1;
        m_rp  = rp;
        m_rpc = rpc;
      end
      if (!m_busy) begin
        if (ibus.inst_addr_ok) m_busy = 1'b1;
      end else if (ibus.inst_data_ok) begin
        m_busy = 1'b0;
        if (m_rv) begin
          m_pc = m_rpc;
          m_rv = 1'b0;
        end else begin
          m_hold     = 1'b1;
          m_hold_pc  = m_pc;
          m_hold_ins = ibus.inst_rdata;
        end
      end
    end
  endtask

  // Inputs are set by the caller in the low phase.
  task automatic step();
    #1;
    compare();
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return RST;
      1:       return 32'hFFFFFFFC;
      2:       return r & 32'hFFFFFFFC;
      default: return r;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic was_busy;
    n_chk  = 0;
    n_fail = 0;
    m_busy = 1'b0;
    m_hold = 1'b0;
    m_pc   = RST;
    m_hold_pc  = RST;
    m_hold_ins = 32'h0;
    m_rv   = 1'b0;
    m_rp   = 0;
    m_rpc  = 32'h0;
    cnt    = 0;
    resetn = 1'b0;
    idle();
    @(negedge clk);
    step();
    step();
    chk("rst_validF", {31'b0, validF}, 32'h0);
    chk("rst_req", {31'b0, ibus.inst_req}, 32'h0);
    chk("rst_pcF", pcF, RST);
    chk("rst_instrF", instrF, 32'h0);

    // first fetch, zero-wait bus
    resetn = 1'b1;
    ibus.inst_addr_ok = 1'b1;
    #1;
    chk("first_req", {31'b0, ibus.inst_req}, 32'h1);
    chk("first_addr", ibus.inst_addr, RST);
    step();
    idle();
    ibus.inst_data_ok = 1'b1;
    ibus.inst_rdata   = 32'h24020001;
    step();
    idle();
    chk("first_valid", {31'b0, validF}, 32'h1);
    chk("first_instr", instrF, 32'h24020001);
    chk("first_pcF", pcF, 32'hBFC00000);
    chk("first_pc4", PcPlus4F, 32'hBFC00004);
    step();
    chk("seq_addr", ibus.inst_addr, 32'hBFC00004);

    // decode stall in HOLD
    ibus.inst_addr_ok = 1'b1;
    step();
    idle();
    ibus.inst_data_ok = 1'b1;
    ibus.inst_rdata   = 32'h8C220000;
    step();
    idle();
    stallF = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", {31'b0, validF}, 32'h1);
      chk("stall_pcF", pcF, 32'hBFC00004);
      chk("stall_req", {31'b0, ibus.inst_req}, 32'h0);
    end
    stallF = 1'b0;
    step();
    chk("unstall_addr", ibus.inst_addr, 32'hBFC00008);

    // jump during WAIT drops the returned word
    ibus.inst_addr_ok = 1'b1;
    step();
    idle();
    jump1D    = 1'b1;
    pc_jump1D = 32'hBFC00100;
    step();
    idle();
    ibus.inst_data_ok = 1'b1;
    ibus.inst_rdata   = 32'hDEADBEEF;
    step();
    idle();
    chk("jmp_valid", {31'b0, validF}, 32'h0);
    chk("jmp_addr", ibus.inst_addr, 32'hBFC00100);

    // redirect while address not yet accepted
    br_redirectE = 1'b1;
    br_targetE   = 32'h80001000;
    for (int i = 0; i < 3; i++) begin
      step();
      idle();
      chk("hold_addr", ibus.inst_addr, 32'hBFC00100);
    end
    ibus.inst_addr_ok = 1'b1;
    step();
    idle();
    ibus.inst_data_ok = 1'b1;
    step();
    idle();
    chk("br_valid", {31'b0, validF}, 32'h0);
    chk("br_addr", ibus.inst_addr, 32'h80001000);

    // exception beats branch in the same cycle
    ibus.inst_addr_ok = 1'b1;
    step();
    idle();
    ibus.inst_data_ok = 1'b1;
    ibus.inst_rdata   = 32'h00000000;
    step();
    idle();
    exc_valid    = 1'b1;
    exc_pc       = EXC;
    br_redirectE = 1'b1;
    br_targetE   = 32'h80001000;
    step();
    idle();
    chk("exc_addr", ibus.inst_addr, 32'hBFC00380);

    // wrap-around of sequential PC
    br_redirectE      = 1'b1;
    br_targetE        = 32'hFFFFFFFC;
    ibus.inst_addr_ok = 1'b1;
    step();
    idle();
    ibus.inst_data_ok = 1'b1;
    step();
    idle();
    chk("wrap_tgt", ibus.inst_addr, 32'hFFFFFFFC);
    ibus.inst_addr_ok = 1'b1;
    step();
    idle();
    ibus.inst_data_ok = 1'b1;
    ibus.inst_rdata   = 32'h1234ABCD;
    step();
    idle();
    chk("wrap_pc4", PcPlus4F, 32'h00000000);
    step();
    chk("wrap_addr", ibus.inst_addr, 32'h00000000);

    // reset while waiting for data
    ibus.inst_addr_ok = 1'b1;
    step();
    idle();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    ibus.inst_data_ok = 1'b1;
    ibus.inst_rdata   = 32'hCAFEF00D;
    step();
    idle();
    chk("rwait_req", {31'b0, ibus.inst_req}, 32'h1);
    chk("rwait_addr", ibus.inst_addr, RST);
    chk("rwait_valid", {31'b0, validF}, 32'h0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      resetn       = ($urandom_range(0, 299) != 0);
      stallF       = ($urandom_range(0, 2) == 0);
      exc_valid    = ($urandom_range(0, 39) == 0);
      exc_pc       = pick();
      br_redirectE = ($urandom_range(0, 11) == 0);
      br_targetE   = pick();
      jump1D       = ($urandom_range(0, 9) == 0);
      pc_jump1D    = pick();
      ibus.inst_addr_ok = $urandom_range(0, 1) == 1;
      ibus.inst_rdata   = $urandom;
      if (m_busy) begin
        if (cnt == 0) ibus.inst_data_ok = 1'b1;
        else cnt--;
      end
      was_busy = m_busy;
      step();
      if (m_busy && !was_busy) cnt = $urandom_range(0, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
